// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipeline control slice:
// bundle widths, bundle bit positions and forwarding encodings.
package ctrl_pipe_pkg;

  localparam int WB_W  = 2;
  localparam int M_W   = 3;
  localparam int EXE_W = 4;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int M_BRANCH   = 0;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 2;

  localparam int EXE_REGDST   = 0;
  localparam int EXE_ALUOP_LO = 1;
  localparam int EXE_ALUOP_HI = 2;
  localparam int EXE_ALUSRC   = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [M_W-1:0]   m;
    logic [EXE_W-1:0] exe;
  } ctl_t;

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// Operand forwarding select for one ALU source register.
// The younger MEM result wins over the older WB result.
module fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_i,
  input  logic            mem_wr_i,
  input  logic [RA_W-1:0] mem_dst_i,
  input  logic            wb_wr_i,
  input  logic [RA_W-1:0] wb_dst_i,
  output fwd_e            sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wr_i
                && (mem_dst_i != '0)
                && (mem_dst_i == src_i);
  assign wb_hit  = wb_wr_i
                && (wb_dst_i != '0)
                && (wb_dst_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush and operand forwarding.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [M_W-1:0]   id_m,
  input  logic [EXE_W-1:0] id_exe,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             mem_zero,
  output logic [EXE_W-1:0] ex_exe,
  output logic [M_W-1:0]   ex_m,
  output logic [WB_W-1:0]  ex_wb,
  output logic [M_W-1:0]   mem_m,
  output logic [WB_W-1:0]  mem_wb,
  output logic [WB_W-1:0]  wb_wb,
  output logic [RA_W-1:0]  mem_dst,
  output logic [RA_W-1:0]  wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             pc_src,
  output logic             if_flush
);

  ctl_t            idex_d, idex_q;
  logic [RA_W-1:0] rs_d, rs_q;
  logic [RA_W-1:0] rt_d, rt_q;
  logic [RA_W-1:0] rd_d, rd_q;

  logic [WB_W-1:0] exmem_wb_d, exmem_wb_q;
  logic [M_W-1:0]  exmem_m_d, exmem_m_q;
  logic [RA_W-1:0] exmem_dst_d, exmem_dst_q;

  logic [WB_W-1:0] memwb_wb_q;
  logic [RA_W-1:0] memwb_dst_q;

  logic [RA_W-1:0] ex_dst;
  logic            load_use;
  logic            taken;
  fwd_e            sel_a, sel_b;

  assign ex_dst = idex_q.exe[EXE_REGDST] ? rd_q : rt_q;

  assign taken = exmem_m_q[M_BRANCH] & mem_zero;

  assign load_use = idex_q.m[M_MEMREAD]
                 && (rt_q != '0)
                 && ((rt_q == id_rs) || (rt_q == id_rt));

  // A taken branch squashes the stalled instruction anyway.
  assign stall    = load_use & ~taken;
  assign pc_src   = taken;
  assign if_flush = taken;

  always_comb begin
    idex_d.wb   = id_wb;
    idex_d.m    = id_m;
    idex_d.exe  = id_exe;
    rs_d        = id_rs;
    rt_d        = id_rt;
    rd_d        = id_rd;
    exmem_wb_d  = idex_q.wb;
    exmem_m_d   = idex_q.m;
    exmem_dst_d = ex_dst;
    if (taken || load_use) begin
      idex_d = '0;
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
    end
    if (taken) begin
      exmem_wb_d  = '0;
      exmem_m_d   = '0;
      exmem_dst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      exmem_wb_q  <= '0;
      exmem_m_q   <= '0;
      exmem_dst_q <= '0;
      memwb_wb_q  <= '0;
      memwb_dst_q <= '0;
    end else begin
      idex_q      <= idex_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_m_q   <= exmem_m_d;
      exmem_dst_q <= exmem_dst_d;
      memwb_wb_q  <= exmem_wb_q;
      memwb_dst_q <= exmem_dst_q;
    end
  end

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .src_i     (rs_q),
    .mem_wr_i  (exmem_wb_q[WB_REGWRITE]),
    .mem_dst_i (exmem_dst_q),
    .wb_wr_i   (memwb_wb_q[WB_REGWRITE]),
    .wb_dst_i  (memwb_dst_q),
    .sel_o     (sel_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .src_i     (rt_q),
    .mem_wr_i  (exmem_wb_q[WB_REGWRITE]),
    .mem_dst_i (exmem_dst_q),
    .wb_wr_i   (memwb_wb_q[WB_REGWRITE]),
    .wb_dst_i  (memwb_dst_q),
    .sel_o     (sel_b)
  );

  assign fwd_a   = sel_a;
  assign fwd_b   = sel_b;
  assign ex_exe  = idex_q.exe;
  assign ex_m    = idex_q.m;
  assign ex_wb   = idex_q.wb;
  assign mem_m   = exmem_m_q;
  assign mem_wb  = exmem_wb_q;
  assign mem_dst = exmem_dst_q;
  assign wb_wb   = memwb_wb_q;
  assign wb_dst  = memwb_dst_q;

endmodule
